// File: rtl/gb_regfile_pkg.sv
// Shared constants for the GameBuddy register file: register/pair indices, IDU ops,
// address-source selects and flag bit positions.
package gb_regfile_pkg;

    localparam logic [2:0] REG_B    = 3'd0;
    localparam logic [2:0] REG_C    = 3'd1;
    localparam logic [2:0] REG_D    = 3'd2;
    localparam logic [2:0] REG_E    = 3'd3;
    localparam logic [2:0] REG_H    = 3'd4;
    localparam logic [2:0] REG_L    = 3'd5;
    localparam logic [2:0] REG_NONE = 3'd6;
    localparam logic [2:0] REG_A    = 3'd7;

    localparam logic [1:0] PAIR_BC = 2'd0;
    localparam logic [1:0] PAIR_DE = 2'd1;
    localparam logic [1:0] PAIR_HL = 2'd2;
    localparam logic [1:0] PAIR_SP = 2'd3;

    localparam logic [1:0] IDU_NONE = 2'd0;
    localparam logic [1:0] IDU_INC  = 2'd1;
    localparam logic [1:0] IDU_DEC  = 2'd2;

    localparam logic [1:0] ADDR_PC    = 2'd0;
    localparam logic [1:0] ADDR_PAIR  = 2'd1;
    localparam logic [1:0] ADDR_SP    = 2'd2;
    localparam logic [1:0] ADDR_HIGHC = 2'd3;

    // Positions within the 4-bit {Z,N,H,C} flag nibble
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/gb_idu.sv
// Combinational W-bit increment/decrement unit with natural modulo-2^W wrap.
// Reserved/none ops pass the input through unchanged.
module gb_idu
    import gb_regfile_pkg::*;
#(
    parameter int W = 16
)(
    input  logic [W-1:0] din,
    input  logic [1:0]   op,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            IDU_INC: dout = din + W'(1);
            IDU_DEC: dout = din - W'(1);
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/gb_regfile_v2.sv
// GameBuddy CPU register file: 8-bit A..L, F, 16-bit SP/PC, pair access with IDU,
// masked flags, PC sequencer and address mux. Optional macro: GB_REGFILE_BYPASS_EN.
module gb_regfile_v2
    import gb_regfile_pkg::*;
#(
    parameter int                  DATA_W   = 8,
    parameter logic [2*DATA_W-1:0] PC_RESET = '0,
    parameter logic [2*DATA_W-1:0] SP_RESET = {{(2*DATA_W-1){1'b1}}, 1'b0}
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [2:0]          wr_sel,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [2:0]          rd_sel_a,
    input  logic [2:0]          rd_sel_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    input  logic [1:0]          pair_sel,
    input  logic                pair_wr_en,
    input  logic [2*DATA_W-1:0] pair_wr_data,
    input  logic [1:0]          idu_op,
    output logic [2*DATA_W-1:0] pair_rd_data,
    input  logic                pc_inc,
    input  logic                pc_load,
    input  logic [2*DATA_W-1:0] pc_load_data,
    output logic [2*DATA_W-1:0] pc_out,
    input  logic                flags_wr_en,
    input  logic [3:0]          flags_mask,
    input  logic [3:0]          flags_in,
    output logic [DATA_W-1:0]   flags_out,
    input  logic [1:0]          addr_sel,
    output logic [2*DATA_W-1:0] addr_bus
);

    localparam int PW = 2 * DATA_W;

    logic [DATA_W-1:0] reg_a, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l;
    logic [PW-1:0]     sp, pc;
    logic [3:0]        flags, flags_next;

    logic [PW-1:0] pair_cur, idu_result, pair_next, pc_plus1;
    logic [PW-1:0] pair_view, sp_view;
    logic          idu_active, pair_upd;
    logic          upd_bc, upd_de, upd_hl, upd_sp;

    always_comb begin
        pair_cur = sp;
        case (pair_sel)
            PAIR_BC: pair_cur = {reg_b, reg_c};
            PAIR_DE: pair_cur = {reg_d, reg_e};
            PAIR_HL: pair_cur = {reg_h, reg_l};
            default: pair_cur = sp;
        endcase
    end

    gb_idu #(.W(PW)) u_pair_idu (
        .din  (pair_cur),
        .op   (idu_op),
        .dout (idu_result)
    );

    gb_idu #(.W(PW)) u_pc_inc (
        .din  (pc),
        .op   (pc_inc ? IDU_INC : IDU_NONE),
        .dout (pc_plus1)
    );

    // A full pair write beats the IDU, which in turn beats any byte write into that pair
    assign idu_active = ((idu_op == IDU_INC) || (idu_op == IDU_DEC)) && !pair_wr_en;
    assign pair_upd   = pair_wr_en || idu_active;
    assign pair_next  = pair_wr_en ? pair_wr_data : idu_result;
    assign upd_bc     = pair_upd && (pair_sel == PAIR_BC);
    assign upd_de     = pair_upd && (pair_sel == PAIR_DE);
    assign upd_hl     = pair_upd && (pair_sel == PAIR_HL);
    assign upd_sp     = pair_upd && (pair_sel == PAIR_SP);

    always_comb begin
        flags_next         = flags;
        flags_next[FLAG_Z] = flags_mask[FLAG_Z] ? flags_in[FLAG_Z] : flags[FLAG_Z];
        flags_next[FLAG_N] = flags_mask[FLAG_N] ? flags_in[FLAG_N] : flags[FLAG_N];
        flags_next[FLAG_H] = flags_mask[FLAG_H] ? flags_in[FLAG_H] : flags[FLAG_H];
        flags_next[FLAG_C] = flags_mask[FLAG_C] ? flags_in[FLAG_C] : flags[FLAG_C];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_c <= '0;
            reg_d <= '0;
            reg_e <= '0;
            reg_h <= '0;
            reg_l <= '0;
            flags <= '0;
            sp    <= SP_RESET;
            pc    <= PC_RESET;
        end else begin
            if (wr_en && (wr_sel == REG_A)) reg_a <= wr_data;

            if (upd_bc) begin
                reg_b <= pair_next[PW-1:DATA_W];
                reg_c <= pair_next[DATA_W-1:0];
            end else begin
                if (wr_en && (wr_sel == REG_B)) reg_b <= wr_data;
                if (wr_en && (wr_sel == REG_C)) reg_c <= wr_data;
            end

            if (upd_de) begin
                reg_d <= pair_next[PW-1:DATA_W];
                reg_e <= pair_next[DATA_W-1:0];
            end else begin
                if (wr_en && (wr_sel == REG_D)) reg_d <= wr_data;
                if (wr_en && (wr_sel == REG_E)) reg_e <= wr_data;
            end

            if (upd_hl) begin
                reg_h <= pair_next[PW-1:DATA_W];
                reg_l <= pair_next[DATA_W-1:0];
            end else begin
                if (wr_en && (wr_sel == REG_H)) reg_h <= wr_data;
                if (wr_en && (wr_sel == REG_L)) reg_l <= wr_data;
            end

            if (upd_sp) sp <= pair_next;

            if (pc_load)     pc <= pc_load_data;
            else if (pc_inc) pc <= pc_plus1;

            if (flags_wr_en) flags <= flags_next;
        end
    end

    function automatic logic [DATA_W-1:0] reg_value(input logic [2:0] sel);
        case (sel)
            REG_B:   return reg_b;
            REG_C:   return reg_c;
            REG_D:   return reg_d;
            REG_E:   return reg_e;
            REG_H:   return reg_h;
            REG_L:   return reg_l;
            REG_A:   return reg_a;
            default: return '0;
        endcase
    endfunction

    always_comb begin
`ifdef GB_REGFILE_BYPASS_EN
        rd_data_a = (wr_en && (wr_sel == rd_sel_a) && (wr_sel != REG_NONE)) ? wr_data : reg_value(rd_sel_a);
        rd_data_b = (wr_en && (wr_sel == rd_sel_b) && (wr_sel != REG_NONE)) ? wr_data : reg_value(rd_sel_b);
        pair_view = pair_wr_en ? pair_wr_data : pair_cur;
        sp_view   = (pair_wr_en && (pair_sel == PAIR_SP)) ? pair_wr_data : sp;
`else
        rd_data_a = reg_value(rd_sel_a);
        rd_data_b = reg_value(rd_sel_b);
        pair_view = pair_cur;
        sp_view   = sp;
`endif
    end

    always_comb begin
        addr_bus = pc;
        case (addr_sel)
            ADDR_PC:    addr_bus = pc;
            ADDR_PAIR:  addr_bus = pair_view;
            ADDR_SP:    addr_bus = sp_view;
            ADDR_HIGHC: addr_bus = {{DATA_W{1'b1}}, reg_c};
            default:    addr_bus = pc;
        endcase
    end

    assign pair_rd_data = pair_view;
    assign pc_out       = pc;
    assign flags_out    = {flags, {(DATA_W-4){1'b0}}};

endmodule

// File: tb/tb_gb_regfile_v2.sv
// Directed self-checking bench for gb_regfile_v2; expectations follow GB_REGFILE_BYPASS_EN if defined.
module tb_gb_regfile_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [7:0]  wr_data;
    logic [2:0]  rd_sel_a, rd_sel_b;
    logic [7:0]  rd_data_a, rd_data_b;
    logic [1:0]  pair_sel;
    logic        pair_wr_en;
    logic [15:0] pair_wr_data;
    logic [1:0]  idu_op;
    logic [15:0] pair_rd_data;
    logic        pc_inc, pc_load;
    logic [15:0] pc_load_data, pc_out;
    logic        flags_wr_en;
    logic [3:0]  flags_mask, flags_in;
    logic [7:0]  flags_out;
    logic [1:0]  addr_sel;
    logic [15:0] addr_bus;

    int checks = 0;
    int errors = 0;

`ifdef GB_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    gb_regfile_v2 dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .pair_sel(pair_sel), .pair_wr_en(pair_wr_en), .pair_wr_data(pair_wr_data),
        .idu_op(idu_op), .pair_rd_data(pair_rd_data),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_data(pc_load_data), .pc_out(pc_out),
        .flags_wr_en(flags_wr_en), .flags_mask(flags_mask), .flags_in(flags_in),
        .flags_out(flags_out), .addr_sel(addr_sel), .addr_bus(addr_bus)
    );

    task automatic drive_idle();
        wr_en = 0; wr_sel = 3'd6; wr_data = 8'h00;
        pair_wr_en = 0; pair_wr_data = 16'h0000; idu_op = 2'd0;
        pc_inc = 0; pc_load = 0; pc_load_data = 16'h0000;
        flags_wr_en = 0; flags_mask = 4'h0; flags_in = 4'h0;
    endtask

    // Inputs change on the falling edge; results are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset();
        logic [7:0] exp_val;
        for (int i = 0; i < 8; i++) begin
            if (i != 6) begin
                wr_en = 1; wr_sel = 3'(i); wr_data = 8'hA5;
                step();
            end
        end
        flags_wr_en = 1; flags_mask = 4'hF; flags_in = 4'hF;
        pc_load = 1; pc_load_data = 16'h1234;
        pair_sel = 2'd3; pair_wr_en = 1; pair_wr_data = 16'h4321;
        step();
        rd_sel_a = 3'd7; #1;
        checks++;
        if (rd_data_a !== 8'hA5) begin errors++; $display("[TB] FAIL pre_reset_a got %h exp a5", rd_data_a); end
        #2;
        rst = 0;
        #1;
        for (int i = 0; i < 8; i++) begin
            rd_sel_a = 3'(i); #1;
            exp_val = 8'h00;
            checks++;
            if (rd_data_a !== exp_val) begin errors++; $display("[TB] FAIL reset_reg%0d got %h exp %h", i, rd_data_a, exp_val); end
        end
        addr_sel = 2'd2; #1;
        checks++;
        if (flags_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_flags got %h exp 00", flags_out); end
        checks++;
        if (pc_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc got %h exp 0000", pc_out); end
        checks++;
        if (addr_bus !== 16'hFFFE) begin errors++; $display("[TB] FAIL reset_sp_addr got %h exp fffe", addr_bus); end
        @(negedge clk);
        rst = 1;
        addr_sel = 2'd0;
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_sel = 3'd0; wr_data = 8'h12;
        rd_sel_a = 3'd0; rd_sel_b = 3'd6;
        #1;
        checks++;
        if (rd_data_a !== (BYPASS ? 8'h12 : 8'h00)) begin errors++; $display("[TB] FAIL same_cycle_b got %h exp %h", rd_data_a, BYPASS ? 8'h12 : 8'h00); end
        step();
        checks++;
        if (rd_data_a !== 8'h12) begin errors++; $display("[TB] FAIL read_b got %h exp 12", rd_data_a); end
        checks++;
        if (rd_data_b !== 8'h00) begin errors++; $display("[TB] FAIL read_none got %h exp 00", rd_data_b); end
        wr_en = 1; wr_sel = 3'd1; wr_data = 8'h44; step();
        wr_en = 1; wr_sel = 3'd2; wr_data = 8'h56; step();
        wr_en = 1; wr_sel = 3'd3; wr_data = 8'h78; step();
        // Write to index 6 must not disturb anything
        wr_en = 1; wr_sel = 3'd6; wr_data = 8'hEE; rd_sel_b = 3'd6; step();
        rd_sel_a = 3'd1; rd_sel_b = 3'd3; #1;
        checks++;
        if (rd_data_a !== 8'h44) begin errors++; $display("[TB] FAIL read_c got %h exp 44", rd_data_a); end
        checks++;
        if (rd_data_b !== 8'h78) begin errors++; $display("[TB] FAIL read_e got %h exp 78", rd_data_b); end
        rd_sel_b = 3'd6; #1;
        checks++;
        if (rd_data_b !== 8'h00) begin errors++; $display("[TB] FAIL read_none_after_wr got %h exp 00", rd_data_b); end
        pair_sel = 2'd0; #1;
        checks++;
        if (pair_rd_data !== 16'h1244) begin errors++; $display("[TB] FAIL pair_bc got %h exp 1244", pair_rd_data); end
    endtask

    task automatic test_idu();
        pair_sel = 2'd2; pair_wr_en = 1; pair_wr_data = 16'hFFFF; step();
        pair_sel = 2'd2; idu_op = 2'd1; wr_en = 1; wr_sel = 3'd7; wr_data = 8'h5A; step();
        rd_sel_a = 3'd7; #1;
        checks++;
        if (pair_rd_data !== 16'h0000) begin errors++; $display("[TB] FAIL hl_inc_wrap got %h exp 0000", pair_rd_data); end
        checks++;
        if (rd_data_a !== 8'h5A) begin errors++; $display("[TB] FAIL a_with_hl_inc got %h exp 5a", rd_data_a); end
        idu_op = 2'd2; step();
        checks++;
        if (pair_rd_data !== 16'hFFFF) begin errors++; $display("[TB] FAIL hl_dec_wrap got %h exp ffff", pair_rd_data); end
        idu_op = 2'd3; step();
        checks++;
        if (pair_rd_data !== 16'hFFFF) begin errors++; $display("[TB] FAIL idu_reserved got %h exp ffff", pair_rd_data); end
        pair_sel = 2'd1; idu_op = 2'd2; step();
        checks++;
        if (pair_rd_data !== 16'h5677) begin errors++; $display("[TB] FAIL de_dec got %h exp 5677", pair_rd_data); end
        pair_sel = 2'd3; idu_op = 2'd1; step();
        addr_sel = 2'd2; #1;
        checks++;
        if (addr_bus !== 16'hFFFF) begin errors++; $display("[TB] FAIL sp_inc got %h exp ffff", addr_bus); end
        checks++;
        if (flags_out !== 8'h00) begin errors++; $display("[TB] FAIL idu_flags got %h exp 00", flags_out); end
        addr_sel = 2'd0;
    endtask

    task automatic test_conflict();
        pair_sel = 2'd2; pair_wr_en = 1; pair_wr_data = 16'hBEEF; idu_op = 2'd1;
        wr_en = 1; wr_sel = 3'd5; wr_data = 8'h00;
        step();
        checks++;
        if (pair_rd_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL pair_over_idu got %h exp beef", pair_rd_data); end
        pair_sel = 2'd2; idu_op = 2'd1; wr_en = 1; wr_sel = 3'd4; wr_data = 8'h00;
        step();
        rd_sel_a = 3'd4; rd_sel_b = 3'd5; #1;
        checks++;
        if (rd_data_a !== 8'hBE) begin errors++; $display("[TB] FAIL idu_over_h got %h exp be", rd_data_a); end
        checks++;
        if (rd_data_b !== 8'hF0) begin errors++; $display("[TB] FAIL idu_l got %h exp f0", rd_data_b); end
    endtask

    task automatic test_bypass();
        pair_sel = 2'd1; pair_wr_en = 1; pair_wr_data = 16'h1234; addr_sel = 2'd1;
        #1;
        checks++;
        if (pair_rd_data !== (BYPASS ? 16'h1234 : 16'h5677)) begin errors++; $display("[TB] FAIL pair_same_cycle got %h exp %h", pair_rd_data, BYPASS ? 16'h1234 : 16'h5677); end
        checks++;
        if (addr_bus !== (BYPASS ? 16'h1234 : 16'h5677)) begin errors++; $display("[TB] FAIL addr_pair_same_cycle got %h exp %h", addr_bus, BYPASS ? 16'h1234 : 16'h5677); end
        step();
        checks++;
        if (addr_bus !== 16'h1234) begin errors++; $display("[TB] FAIL addr_pair got %h exp 1234", addr_bus); end
        addr_sel = 2'd0;
    endtask

    task automatic test_flags();
        flags_wr_en = 1; flags_mask = 4'hF; flags_in = 4'hF; step();
        checks++;
        if (flags_out !== 8'hF0) begin errors++; $display("[TB] FAIL flags_all got %h exp f0", flags_out); end
        flags_wr_en = 1; flags_mask = 4'b0101; flags_in = 4'b0000; step();
        checks++;
        if (flags_out !== 8'hA0) begin errors++; $display("[TB] FAIL flags_masked got %h exp a0", flags_out); end
        flags_wr_en = 0; flags_mask = 4'hF; flags_in = 4'h0; step();
        checks++;
        if (flags_out !== 8'hA0) begin errors++; $display("[TB] FAIL flags_hold got %h exp a0", flags_out); end
    endtask

    task automatic test_pc();
        pc_load = 1; pc_load_data = 16'hFFFF; step();
        addr_sel = 2'd0; #1;
        checks++;
        if (addr_bus !== 16'hFFFF) begin errors++; $display("[TB] FAIL pc_load got %h exp ffff", addr_bus); end
        pc_inc = 1; step();
        checks++;
        if (pc_out !== 16'h0000) begin errors++; $display("[TB] FAIL pc_wrap got %h exp 0000", pc_out); end
        pc_inc = 1; pc_load = 1; pc_load_data = 16'h0150; step();
        checks++;
        if (pc_out !== 16'h0150) begin errors++; $display("[TB] FAIL pc_load_prio got %h exp 0150", pc_out); end
        pc_inc = 1; pair_sel = 2'd2; idu_op = 2'd1; step();
        checks++;
        if (pc_out !== 16'h0151) begin errors++; $display("[TB] FAIL pc_inc got %h exp 0151", pc_out); end
        step();
        checks++;
        if (pc_out !== 16'h0151) begin errors++; $display("[TB] FAIL pc_hold got %h exp 0151", pc_out); end
        addr_sel = 2'd3; #1;
        checks++;
        if (addr_bus !== 16'hFF44) begin errors++; $display("[TB] FAIL addr_highc got %h exp ff44", addr_bus); end
        addr_sel = 2'd1; pair_sel = 2'd2; #1;
        checks++;
        if (addr_bus !== 16'hBEF1) begin errors++; $display("[TB] FAIL addr_hl got %h exp bef1", addr_bus); end
    endtask

    initial begin
        rst = 0;
        drive_idle();
        rd_sel_a = 3'd0; rd_sel_b = 3'd6; pair_sel = 2'd0; addr_sel = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1;
        test_reset();
        test_write_read();
        test_idu();
        test_conflict();
        test_bypass();
        test_flags();
        test_pc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gb_regfile_v2.md
Name: gb_regfile_v2

Overview:
- Parametrised second-generation CPU register file for the GameBuddy core: A, B, C, D, E, H, L, F, plus 16-bit SP and PC.
- Two independent 8-bit read ports and one 8-bit write port.
- 16-bit pair read/write on BC/DE/HL/SP, with an integrated increment/decrement unit (IDU) for HL+/HL-/INC rr/DEC rr.
- Masked flag writes, a PC sequencer (increment/load), and an address-bus source mux.
- Sits between the decoder/sequencer and the ALU/memory interface; everything is clocked on the single core clock.

Parameters:
- DATA_W, 8, register width; pair/PC/SP/addr width = 2*DATA_W (PW below)
- PC_RESET, 16'h0000, PC value after reset (PW bits)
- SP_RESET, 16'hFFFE, SP value after reset (PW bits)

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  8-bit register write enable
- wr_sel  in  3  write index: B=0 C=1 D=2 E=3 H=4 L=5 (6)=none A=7
- wr_data  in  DATA_W  8-bit write data
- rd_sel_a  in  3  read index, port A (same encoding)
- rd_sel_b  in  3  read index, port B
- rd_data_a  out  DATA_W  port A data; index 6 returns 0
- rd_data_b  out  DATA_W  port B data; index 6 returns 0
- pair_sel  in  2  pair: 0=BC 1=DE 2=HL 3=SP
- pair_wr_en  in  1  16-bit pair write
- pair_wr_data  in  PW  pair write data
- idu_op  in  2  0=none 1=inc 2=dec 3=reserved (treated as none)
- pair_rd_data  out  PW  current value of the selected pair
- pc_inc  in  1  PC <= PC+1
- pc_load  in  1  PC <= pc_load_data
- pc_load_data  in  PW  PC load value
- pc_out  out  PW  current PC
- flags_wr_en  in  1  flag write enable
- flags_mask  in  4  per-flag enable {Z,N,H,C}
- flags_in  in  4  new {Z,N,H,C}
- flags_out  out  DATA_W  F register; Z,N,H,C in the top 4 bits, lower bits always 0
- addr_sel  in  2  0=PC 1=selected pair 2=SP 3={all-ones byte, C}
- addr_bus  out  PW  combinational address source

Behaviour:
- Reset (rst low, async): A–L=0, F=0, SP=SP_RESET, PC=PC_RESET. Outputs follow combinationally. Reset mid-operation discards any pending update.
- Reads are combinational, zero latency, and reflect state at the start of the cycle (no bypass unless the optional feature is enabled).
- 8-bit write: on posedge, if wr_en and wr_sel!=6, the selected register <= wr_data. Writes to index 6 are ignored.
- Pair write: if pair_wr_en, the selected pair (high byte = B/D/H, low byte = C/E/L; SP whole) <= pair_wr_data.
- IDU: if idu_op=inc/dec and pair_wr_en=0, the selected pair <= pair ±1, modulo 2^PW.
  - FFFF+1 wraps to 0000; 0000-1 wraps to FFFF.
  - The IDU never touches F.
- Same-cycle priority per byte: pair_wr_en > IDU > 8-bit write.
  - Example: wr_sel=L with an HL IDU op → the IDU result wins for both H and L.
  - An 8-bit write to a register outside the active pair still occurs, e.g. A write together with HL+ (LD A,(HL+)).
- Flags: if flags_wr_en, F[top4][i] <= flags_in[i] where flags_mask[i], else unchanged. The low DATA_W-4 bits stay 0 permanently.
- PC:
  - pc_load has priority over pc_inc.
  - pc_inc wraps FFFF→0000.
  - Neither asserted → hold.
  - PC is independent of pair ops.
- addr_sel=3 yields {DATA_W ones, C} (LDH (C) high page).

Optional Feature:
- Macro GB_REGFILE_BYPASS_EN.
- Defined:
  - rd_data_a/b return wr_data when wr_en and rd_sel==wr_sel (≠6).
  - pair_rd_data and addr_bus (sel 1/2) return pair_wr_data when pair_wr_en is active on the same pair.
  - IDU results are not bypassed.
- Undefined: all reads show pre-edge state only.

Decomposition:
- Shared package gb_regfile_pkg:
  - register index localparams REG_B..REG_A and REG_NONE=6
  - pair codes PAIR_BC/DE/HL/SP
  - IDU_NONE/INC/DEC
  - ADDR_PC/PAIR/SP/HIGHC
  - flag bit positions FLAG_Z/N/H/C
- One natural sub-module: gb_idu (combinational PW-bit ±1 with wrap), reused later for the SP/PC adders.

Test Plan:
- Reset: drive rst=0 async mid-cycle → A–L=0, flags_out=8'h00, pc_out=16'h0000, addr_bus(sel2)=16'hFFFE.
- 8-bit write B=8'h12, then read rd_sel_a=0, rd_sel_b=6 → next cycle rd_data_a=8'h12, rd_data_b=8'h00; same-cycle read shows 8'h00 without the macro, 8'h12 with it.
- HL=16'hFFFF, idu_op=inc with wr_sel=A, wr_data=8'h5A → HL=16'h0000, A=8'h5A. Then idu_op=dec → HL=16'hFFFF.
- Conflict: pair_wr_en HL=16'hBEEF, idu_op=inc, wr_sel=L, wr_data=8'h00 → HL=16'hBEEF.
- Flags F=8'hF0 then flags_wr_en with mask=4'b0101, in=4'b0000 → flags_out=8'hA0.
- PC=16'hFFFF: pc_inc → 16'h0000. pc_inc+pc_load(16'h0150) → 16'h0150. C=8'h44, addr_sel=3 → addr_bus=16'hFF44.
